muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline's EX stage.
- Decodes the R-type Funct field for mult, multu, div, divu, mfhi, mflo, mthi and mtlo, and derives signedness internally, like the pipeline's ALU decode.
- Runs a radix-2 shift-add or restoring-divide sequence over WIDTH cycles.
- Stalls issue through a ready/busy handshake and supports a pipeline flush.

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign-fixed in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;
  logic             a_neg_q, a_neg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept, is_md, is_mthi, is_mtlo, sgn;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_unused;
  logic [2*WIDTH-1:0] prod, prod_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign busy        = (state_q != S_IDLE);
  assign issue_ready = !busy;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign rdata       = (Funct == 6'h10) ? hi_q : (Funct == 6'h12) ? lo_q : '0;

  assign accept  = issue_valid && issue_ready && !flush;
  assign is_md   = (Funct[5:2] == 4'b0110);
  assign is_mthi = (Funct == 6'h11);
  assign is_mtlo = (Funct == 6'h13);
  assign sgn     = !Funct[0];

  // Multiply step adds the multiplicand when the multiplier LSB is set; divide step trial-subtracts.
  assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh     = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff   = {1'b0, div_sh} - {2'b00, b_q};
  assign div_unused = div_diff[WIDTH];
  assign prod       = {acc_hi_q, acc_lo_q};
  assign prod_fix   = neg_q ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_md) begin
            a_neg_d  = sgn & op_a[WIDTH-1];
            neg_d    = (sgn & op_a[WIDTH-1]) ^ (sgn & op_b[WIDTH-1]);
            op_div_d = Funct[1];
            dz_d     = (op_b == '0);
            acc_hi_d = '0;
            acc_lo_d = mag(op_a, sgn);
            b_d      = mag(op_b, sgn);
            cnt_d    = CW'(WIDTH);
            state_d  = S_RUN;
          end else if (is_mthi) begin
            hi_d = op_a;
          end else if (is_mtlo) begin
            lo_d = op_a;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_div_q) begin
            if (!div_diff[WIDTH+1]) begin
              acc_hi_d = div_diff[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_sh[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (op_div_q) begin
            // Divide by zero leaves the raw dividend in the remainder; only the quotient needs forcing.
            lo_d = dz_q ? '1 : cond_neg(acc_lo_q, neg_q);
            hi_d = cond_neg(acc_hi_q, a_neg_q);
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue, checked when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  Funct;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo, rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .Funct(Funct), .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {32'd0, hi}, 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge where busy has fallen.
  task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit tail);
    int n;
    exp_q.push_back({eh, el});
    issue_valid = 1'b1; Funct = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin
        issue_valid = 1'b1; Funct = 6'h11;
        chk({nm, "_ready_while_busy"}, {63'd0, issue_ready}, 64'd0);
      end else begin
        issue_valid = 1'b0; Funct = f;
      end
      op_a = $urandom; op_b = $urandom;
      @(negedge clk);
    end
    issue_valid = 1'b0; Funct = f;
    chk({nm, "_busy_cycles"}, 64'(n), 64'd33);
    chk({nm, "_done_high"}, {63'd0, done}, 64'd1);
    if (tail) begin
      @(negedge clk);
      chk({nm, "_done_single"}, {63'd0, done}, 64'd0);
    end
  endtask

  task automatic issue_one(input logic [5:0] f, input logic [31:0] a, input logic fl);
    issue_valid = 1'b1; Funct = f; op_a = a; op_b = 32'd7; flush = fl;
    @(posedge clk); #1;
    issue_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; Funct = 6'h00; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_ready", {63'd0, issue_ready}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_m3x5", 6'h18, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    run_op("multu_ffx2", 6'h19, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_op("mult_ffx2", 6'h18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    run_op("div_m7d2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op("div_7dm2", 6'h1A, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b1);
    run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
    run_op("divu_100d0", 6'h1B, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("div_m100d0", 6'h1A, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_100d7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

    // Back-to-back: second issue lands on the first idle edge.
    run_op("b2b_mult", 6'h18, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    run_op("b2b_div", 6'h1A, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b1);

    issue_one(6'h13, 32'h0000_1234, 1'b0);
    @(negedge clk);
    chk("mtlo_lo", {32'd0, lo}, 64'h1234);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    chk("mtlo_done", {63'd0, done}, 64'd0);
    Funct = 6'h12; #1;
    chk("mflo_rdata", {32'd0, rdata}, 64'h1234);
    issue_one(6'h11, 32'h0000_ABCD, 1'b0);
    Funct = 6'h10;
    @(negedge clk);
    chk("mfhi_rdata", {32'd0, rdata}, 64'hABCD);
    Funct = 6'h20; #1;
    chk("rdata_other", {32'd0, rdata}, 64'd0);

    // Flush mid-divide: no done, HI/LO keep the mt values.
    @(negedge clk);
    issue_one(6'h1B, 32'd1000, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi", {32'd0, hi}, 64'hABCD);
    chk("flush_lo", {32'd0, lo}, 64'h1234);

    issue_one(6'h18, 32'd9, 1'b1);
    chk("flush_issue_busy", {63'd0, busy}, 64'd0);
    issue_one(6'h13, 32'h5555, 1'b1);
    @(negedge clk);
    chk("flush_mtlo_lo", {32'd0, lo}, 64'h1234);

    // Asynchronous reset in the middle of a run.
    issue_one(6'h18, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrun_hi", {32'd0, hi}, 64'd0);
    chk("rstrun_lo", {32'd0, lo}, 64'd0);
    chk("rstrun_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstrun_idle", {63'd0, busy}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
